// File: rtl/dmem_ctrl.sv
// dmem_ctrl: load/store front-end between the core LSU and a word-wide data RAM.
// Turns byte-addressed LB/LH/LW/LBU/LHU/SB/SH/SW requests into RAM word
// address, byte strobes and lane-replicated write data. It waits for the RAM's
// registered completion and returns extended load data over a valid/ready
// response. Range, size, alignment and timeout errors never touch the RAM.
//
// Optional feature macro: DMEM_MISALIGN_CHECK_EN
//   defined   - misaligned half/word accesses are rejected with rsp_err.
//   undefined - misaligned accesses are aligned down and proceed.
//
// Ports
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   req_valid/ready   request handshake (ready only in IDLE)
//   req_we            1 = store, 0 = load
//   req_size          00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned      zero-extend byte/half loads
//   req_addr          byte address
//   req_wdata         right-aligned store data
//   rsp_valid/ready   response handshake; data/err held until rsp_ready
//   rsp_rdata         extended load data, 0 for stores and errors
//   rsp_err           access error
//   ram_ce/we/wstrb   RAM enable, write enable, byte strobes
//   ram_addr          RAM word address
//   ram_wdata         lane-replicated store data
//   ram_rdata         RAM read word
//   ram_rdata_valid   RAM completion, one cycle after ram_ce
module dmem_ctrl #(
    parameter int unsigned ADDR_WIDTH = 12,
    parameter logic [31:0] BASE_ADDR  = 32'h2000_0000,
    parameter int unsigned TIMEOUT    = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [31:0]           req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [31:0]           rsp_rdata,
    output logic                  rsp_err,
    output logic                  ram_ce,
    output logic                  ram_we,
    output logic [3:0]            ram_wstrb,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [31:0]           ram_wdata,
    input  logic [31:0]           ram_rdata,
    input  logic                  ram_rdata_valid
);

    localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_WAIT,
        S_RESP
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] wait_cnt;

    // Registered request fields needed to format the returning load data.
    logic             we_q;
    logic [1:0]       size_q;
    logic             uns_q;
    logic [1:0]       off_q;

    logic             req_err_c;
    logic             misalign_c;
    logic [3:0]       acc_wstrb_c;
    logic [31:0]      acc_wdata_c;
    logic [31:0]      load_data_c;
    logic [7:0]       load_byte_c;
    logic [15:0]      load_half_c;

    // Alignment check on the incoming request.
    always_comb begin
        misalign_c = 1'b0;
`ifdef DMEM_MISALIGN_CHECK_EN
        if (req_size == 2'b01) begin
            misalign_c = req_addr[0];
        end else if (req_size == 2'b10) begin
            misalign_c = (req_addr[1:0] != 2'b00);
        end
`endif
    end

    // Request check and lane mapping, evaluated at accept time.
    always_comb begin
        req_err_c = (req_addr[31:ADDR_WIDTH+2] != BASE_ADDR[31:ADDR_WIDTH+2])
                  || (req_size == 2'b11) || misalign_c;
        acc_wstrb_c = 4'b0000;
        acc_wdata_c = 32'h0;
        if (req_we) begin
            case (req_size)
                2'b00: begin
                    acc_wstrb_c = 4'b0001 << req_addr[1:0];
                    acc_wdata_c = {4{req_wdata[7:0]}};
                end
                2'b01: begin
                    acc_wstrb_c = req_addr[1] ? 4'b1100 : 4'b0011;
                    acc_wdata_c = {2{req_wdata[15:0]}};
                end
                default: begin
                    acc_wstrb_c = 4'b1111;
                    acc_wdata_c = req_wdata;
                end
            endcase
        end
    end

    // Lane select and sign/zero extension of the returning RAM word.
    always_comb begin
        load_byte_c = ram_rdata[{off_q, 3'b000} +: 8];
        load_half_c = ram_rdata[{off_q[1], 4'b0000} +: 16];
        load_data_c = ram_rdata;
        case (size_q)
            2'b00:   load_data_c = uns_q ? {24'h0, load_byte_c}
                                         : {{24{load_byte_c[7]}}, load_byte_c};
            2'b01:   load_data_c = uns_q ? {16'h0, load_half_c}
                                         : {{16{load_half_c[15]}}, load_half_c};
            default: load_data_c = ram_rdata;
        endcase
        if (we_q) begin
            load_data_c = 32'h0;
        end
    end

    // Control FSM with registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            wait_cnt  <= '0;
            we_q      <= 1'b0;
            size_q    <= 2'b00;
            uns_q     <= 1'b0;
            off_q     <= 2'b00;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'h0;
            rsp_err   <= 1'b0;
            ram_ce    <= 1'b0;
            ram_we    <= 1'b0;
            ram_wstrb <= 4'b0000;
            ram_addr  <= '0;
            ram_wdata <= 32'h0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        we_q      <= req_we;
                        size_q    <= req_size;
                        uns_q     <= req_unsigned;
                        off_q     <= req_addr[1:0];
                        req_ready <= 1'b0;
                        if (req_err_c) begin
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_rdata <= 32'h0;
                            state     <= S_RESP;
                        end else begin
                            ram_ce    <= 1'b1;
                            ram_we    <= req_we;
                            ram_wstrb <= acc_wstrb_c;
                            ram_addr  <= req_addr[ADDR_WIDTH+1:2];
                            ram_wdata <= acc_wdata_c;
                            state     <= S_ACCESS;
                        end
                    end
                end
                S_ACCESS: begin
                    ram_ce    <= 1'b0;
                    ram_we    <= 1'b0;
                    ram_wstrb <= 4'b0000;
                    ram_addr  <= '0;
                    ram_wdata <= 32'h0;
                    wait_cnt  <= '0;
                    state     <= S_WAIT;
                end
                S_WAIT: begin
                    if (ram_rdata_valid) begin
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b0;
                        rsp_rdata <= load_data_c;
                        state     <= S_RESP;
                    end else if (wait_cnt == CNT_LAST) begin
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        rsp_rdata <= 32'h0;
                        state     <= S_RESP;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rsp_err   <= 1'b0;
                        rsp_rdata <= 32'h0;
                        req_ready <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
